branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//  Direct-mapped branch target buffer with 2-bit saturating direction counters.
//  Sits directly upstream of instr_fetch and drives its hit/taken/pred_PC inputs.
//  Lookup is combinational on the current fetch PC.
//  The table is trained by a resolved-branch update port driven from execute.
// PARAMETERS
//  XLEN     32  address/data width
//  IDX_W    4   index bits; ENTRIES = 2**IDX_W (16)
//  TAG_W    26  tag bits = XLEN-IDX_W-2; PC[31:IDX_W+2]
// PORTS
//  clk         in   1     single clock, rising edge
//  rst         in   1     synchronous, active-high reset
//  PC          in   32    current fetch PC (lookup address)
//  upd_en      in   1     resolved branch/jump update strobe
//  upd_PC      in   32    PC of resolved branch
//  upd_taken   in   1     resolved direction
//  upd_target  in   32    resolved target address
//  hit         out  1     PC matches a valid entry
//  taken       out  1     predicted taken
//  pred_PC     out  32    next fetch address
// BEHAVIOUR
//  Entry state: valid (1b), tag (TAG_W), target (32b), ctr (2b).
//  idx = addr[IDX_W+1:2], tag = addr[31:IDX_W+2]; addr[1:0] ignored.
//  Lookup (0-cycle, combinational):
//   - hit = valid[idx] && tag[idx]==tag(PC).
//   - taken = hit && ctr[idx][1].
//   - pred_PC = taken ? target[idx] : PC+32'd4 (mod 2**32 wrap; 0xFFFFFFFC -> 0x0).
//  Update (registered; visible to lookup from next cycle):
//   - Entry hit on upd_PC: ctr += 1 if upd_taken, else ctr -= 1.
//     Saturates at 2'b11 and 2'b00. target <= upd_target only when upd_taken.
//   - Entry miss and upd_taken: allocate/replace.
//     valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken).
//   - Entry miss and !upd_taken: no change; never allocate on not-taken.
//  Aliasing: a different tag at the same idx misses; a taken update evicts.
//  Reset: all valid<=0, all ctr<=2'b01. target/tag need no reset.
//   Outputs are then hit=0, taken=0, pred_PC=PC+4.
//  rst has priority over upd_en: an update in a reset cycle is dropped.
//   Reset mid-operation clears all learned state.
//  Only one update per cycle; upd_en low -> table holds.
// CONFIGURATION
//  BTB_FWD_EN defined:
//   - Lookup at the same idx as an in-flight upd_en sees the post-update entry
//     (valid/tag/target/ctr computed by the update logic) in the same cycle.
//   - A different idx is unaffected.
//  BTB_FWD_EN undefined:
//   - Lookup always sees registered table contents; same-cycle update visible
//     next cycle only.
// TESTING
//  1 rst=1 2 cycles, PC=0x100 -> hit=0, taken=0, pred_PC=0x104.
//  2 upd 0x100 taken tgt 0x200; next cycle PC=0x100 -> hit=1, taken=1,
//    pred_PC=0x200 (ctr=10).
//  3 upd 0x100 not-taken -> ctr=01: hit=1, taken=0, pred_PC=0x104.
//    Then 3x taken -> ctr=11; 1x not-taken -> ctr=10, still taken=1
//    (saturation/hysteresis).
//  4 PC=0x140 (idx 0, new tag) -> hit=0. upd 0x140 taken tgt 0x500 evicts;
//    PC=0x100 -> hit=0, PC=0x140 -> pred_PC=0x500.
//  5 upd 0x300 not-taken on empty entry -> PC=0x300 hit=0.
//    Also: upd_en with rst=1 -> entry not allocated.
//  6 Same cycle PC=0x180 and upd 0x180 taken tgt 0x400:
//    BTB_FWD_EN -> hit=1, pred_PC=0x400 that cycle; without it -> hit=0,
//    then hit=1 next cycle.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-facing bundle for the branch target buffer: lookup PC,
// resolved-branch update port and prediction outputs.
interface branch_target_buffer_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PC;
  logic            upd_en;
  logic [XLEN-1:0] upd_PC;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            hit;
  logic            taken;
  logic [XLEN-1:0] pred_PC;

  modport master (
    output PC, upd_en, upd_PC, upd_taken, upd_target,
    input  hit, taken, pred_PC
  );

  modport slave (
    input  PC, upd_en, upd_PC, upd_taken, upd_target,
    output hit, taken, pred_PC
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Optional macro BTB_FWD_EN forwards a same-cycle update to a lookup at the same index.
module branch_target_buffer #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  branch_target_buffer_if.slave  bus
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             wr_d;
  logic [TAG_W-1:0] tag_d;
  logic [XLEN-1:0]  target_d;
  logic [1:0]       ctr_d;

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_valid;
  logic [TAG_W-1:0] l_tag_e;
  logic [XLEN-1:0]  l_target;
  logic [1:0]       l_ctr;
  logic             unused_addr_lsb;

  assign u_idx = bus.upd_PC[IDX_W+1:2];
  assign u_tag = bus.upd_PC[XLEN-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign l_idx = bus.PC[IDX_W+1:2];
  assign l_tag = bus.PC[XLEN-1:IDX_W+2];
  assign unused_addr_lsb = ^bus.upd_PC[1:0];

  // Not-taken misses never allocate, so only hits or taken misses write.
  always_comb begin
    wr_d     = 1'b0;
    tag_d    = u_tag;
    target_d = target_q[u_idx];
    ctr_d    = ctr_q[u_idx];
    if (bus.upd_en) begin
      if (u_hit) begin
        wr_d = 1'b1;
        if (bus.upd_taken) begin
          target_d = bus.upd_target;
          if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d = ctr_q[u_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        wr_d     = 1'b1;
        target_d = bus.upd_target;
        ctr_d    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (wr_d) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= tag_d;
      target_q[u_idx] <= target_d;
      ctr_q[u_idx]    <= ctr_d;
    end
  end

  always_comb begin
    l_valid  = valid_q[l_idx];
    l_tag_e  = tag_q[l_idx];
    l_target = target_q[l_idx];
    l_ctr    = ctr_q[l_idx];
`ifdef BTB_FWD_EN
    if (wr_d && !rst && (u_idx == l_idx)) begin
      l_valid  = 1'b1;
      l_tag_e  = tag_d;
      l_target = target_d;
      l_ctr    = ctr_d;
    end
`else
`endif
  end

  assign bus.hit     = l_valid && (l_tag_e == l_tag);
  assign bus.taken   = bus.hit && l_ctr[1];
  assign bus.pred_PC = bus.taken ? l_target : bus.PC + XLEN'(4);
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer; checks both the
// forwarding and non-forwarding builds depending on BTB_FWD_EN.
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  branch_target_buffer_if #(.XLEN(32)) bus ();

  branch_target_buffer #(.XLEN(32), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic e_hit, input logic e_taken, input logic [31:0] e_pred);
    bus.PC = pc;
    #1;
    check({tag, ".hit"},   {31'd0, bus.hit},   {31'd0, e_hit});
    check({tag, ".taken"}, {31'd0, bus.taken}, {31'd0, e_taken});
    check({tag, ".pred"},  bus.pred_PC,        e_pred);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bus.upd_en     = 1'b1;
    bus.upd_PC     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
  endtask

  initial begin
    bus.PC = 32'h100;
    bus.upd_en = 1'b0;
    bus.upd_PC = 32'h0;
    bus.upd_taken = 1'b0;
    bus.upd_target = 32'h0;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    look("reset", 32'h100, 1'b0, 1'b0, 32'h104);
    rst = 1'b0;

    // allocate weakly taken
    upd(32'h100, 1'b1, 32'h200);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    look("alloc_lsb_ignored", 32'h102, 1'b1, 1'b1, 32'h200);

    // counter training and hysteresis
    upd(32'h100, 1'b0, 32'h999);
    look("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h200);
    look("ctr10", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h220);
    upd(32'h100, 1'b1, 32'h240);
    look("ctr11_newtgt", 32'h100, 1'b1, 1'b1, 32'h240);
    upd(32'h100, 1'b0, 32'h999);
    look("ctr11_to_10", 32'h100, 1'b1, 1'b1, 32'h240);
    upd(32'h100, 1'b0, 32'h999);
    look("ctr10_to_01", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h999);
    upd(32'h100, 1'b0, 32'h999);
    upd(32'h100, 1'b1, 32'h260);
    look("ctr00_sat_then_01", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h280);
    look("ctr01_to_10", 32'h100, 1'b1, 1'b1, 32'h280);

    // aliasing and eviction at idx 0
    look("alias_miss", 32'h140, 1'b0, 1'b0, 32'h144);
    upd(32'h140, 1'b1, 32'h500);
    look("evicted_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("evict_new", 32'h140, 1'b1, 1'b1, 32'h500);

    // not-taken miss never allocates
    upd(32'h300, 1'b0, 32'h700);
    look("nt_no_alloc", 32'h300, 1'b0, 1'b0, 32'h304);
    look("nt_kept_old", 32'h140, 1'b1, 1'b1, 32'h500);
    look("other_idx_miss", 32'h3C4, 1'b0, 1'b0, 32'h3C8);

    // PC+4 wraps at top of address space
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // update during reset is dropped and learned state cleared
    rst = 1'b1;
    upd(32'h3C4, 1'b1, 32'h800);
    rst = 1'b0;
    look("rst_drop_upd", 32'h3C4, 1'b0, 1'b0, 32'h3C8);
    look("rst_cleared", 32'h140, 1'b0, 1'b0, 32'h144);

    // same-cycle lookup and update
    bus.PC         = 32'h180;
    bus.upd_en     = 1'b1;
    bus.upd_PC     = 32'h180;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h400;
    #1;
`ifdef BTB_FWD_EN
    check("same_cycle.hit",  {31'd0, bus.hit}, 32'd1);
    check("same_cycle.pred", bus.pred_PC,      32'h400);
`else
    check("same_cycle.hit",  {31'd0, bus.hit}, 32'd0);
    check("same_cycle.pred", bus.pred_PC,      32'h184);
`endif
    look("same_cycle_other_idx", 32'h3C4, 1'b0, 1'b0, 32'h3C8);
    bus.PC = 32'h180;
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    look("next_cycle", 32'h180, 1'b1, 1'b1, 32'h400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
